// File: rtl/mc_tag_lookup_pkg.sv
// ============================================================================
// Module : mc_tag_lookup_pkg
// Brief  : Shared helpers for the cache tag lookup pipeline.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_tag_lookup_pkg;

    // Way index width: clog2 with a floor of one bit so WAYS=1 still has a port.
    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_tag_way_cmp.sv
// ============================================================================
// Module : mc_tag_way_cmp
// Brief  : Single-way tag compare qualified by the line valid bit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_tag_way_cmp #(
    parameter int TAG_WIDTH = 12
) (
    input  logic [TAG_WIDTH-1:0] tag,
    input  logic [TAG_WIDTH-1:0] ref_tag,
    input  logic                 vld,
    output logic                 match
);

    localparam int NCH = (TAG_WIDTH + 1) / 2;

    logic [NCH-1:0] w_chunk_eq;

    // 2-bit xnor chunks feed one wide AND; synthesis is free to merge them.
    for (genvar c = 0; c < NCH; c++) begin : g_chunk
        if (2 * c + 1 < TAG_WIDTH) begin : g_pair
            assign w_chunk_eq[c] = ~|(tag[2*c+1:2*c] ^ ref_tag[2*c+1:2*c]);
        end else begin : g_single
            assign w_chunk_eq[c] = ~(tag[2*c] ^ ref_tag[2*c]);
        end
    end

    assign match = vld & (&w_chunk_eq);

endmodule

`default_nettype wire

// File: rtl/mc_tag_lookup.sv
// ============================================================================
// Module : mc_tag_lookup
// Brief  : 2-stage elastic N-way tag lookup returning hit/way and refill victim.
//          Optional multi-hit error flag enabled by `define MC_TAG_MULTIHIT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_tag_lookup
    import mc_tag_lookup_pkg::*;
#(
    parameter int TAG_WIDTH  = 12,
    parameter int WAYS       = 4,
    parameter int USER_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [TAG_WIDTH-1:0]          req_ref,
    input  logic [WAYS*TAG_WIDTH-1:0]     req_tags,
    input  logic [WAYS-1:0]               req_tvld,
    input  logic [USER_WIDTH-1:0]         req_user,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic                          resp_hit,
    output logic [WAYS-1:0]               resp_way_oh,
    output logic [way_bits(WAYS)-1:0]     resp_way,
    output logic [way_bits(WAYS)-1:0]     resp_victim,
    output logic [USER_WIDTH-1:0]         resp_user,
    output logic                          err_multihit,
    input  logic                          err_clr
);

    localparam int WL = way_bits(WAYS);
    localparam logic [WL-1:0] c_last_way = WL'(WAYS - 1);

    logic [WAYS-1:0]       w_match;
    logic                  w_any_inv;
    logic [WL-1:0]         w_first_inv;
    logic                  w_s1_adv;
    logic                  w_s2_adv;
    logic                  w_resp_fire;
    logic                  w_hit;
    logic [WAYS-1:0]       w_way_oh;
    logic [WL-1:0]         w_way;
    logic [WL-1:0]         w_victim;
    logic [WL-1:0]         w_rr_next;

    logic                  r_s1_v;
    logic [WAYS-1:0]       r_s1_match;
    logic                  r_s1_any_inv;
    logic [WL-1:0]         r_s1_first_inv;
    logic [USER_WIDTH-1:0] r_s1_user;

    logic                  r_resp_valid;
    logic                  r_resp_hit;
    logic [WAYS-1:0]       r_resp_way_oh;
    logic [WL-1:0]         r_resp_way;
    logic [WL-1:0]         r_resp_victim;
    logic [USER_WIDTH-1:0] r_resp_user;
    logic                  r_resp_any_inv;
    logic [WL-1:0]         r_rr_ptr;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        mc_tag_way_cmp #(.TAG_WIDTH(TAG_WIDTH)) u_cmp (
            .tag     (req_tags[w*TAG_WIDTH +: TAG_WIDTH]),
            .ref_tag (req_ref),
            .vld     (req_tvld[w]),
            .match   (w_match[w])
        );
    end

    assign w_any_inv = ~&req_tvld;

    always_comb begin
        w_first_inv = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!req_tvld[w]) w_first_inv = WL'(w);
        end
    end

    assign w_resp_fire = r_resp_valid & resp_ready;
    assign w_s2_adv    = ~r_resp_valid | resp_ready;
    assign w_s1_adv    = ~r_s1_v | w_s2_adv;
    assign req_ready   = w_s1_adv;

    always_comb begin
        w_way_oh = '0;
        w_way    = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_s1_match[w]) begin
                w_way_oh    = '0;
                w_way_oh[w] = 1'b1;
                w_way       = WL'(w);
            end
        end
    end

    assign w_hit = |r_s1_match;

    // A lookup loaded into S2 in the same cycle the previous miss retires must
    // already see the advanced round-robin pointer.
    always_comb begin
        w_rr_next = r_rr_ptr;
        if (w_resp_fire && !r_resp_hit && !r_resp_any_inv) begin
            w_rr_next = (r_rr_ptr == c_last_way) ? '0 : r_rr_ptr + WL'(1);
        end
    end

    assign w_victim = r_s1_any_inv ? r_s1_first_inv : w_rr_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_rr_ptr     <= '0;
        end else begin
            if (w_s1_adv) r_s1_v <= req_valid;
            if (w_s2_adv) r_resp_valid <= r_s1_v;
            r_rr_ptr <= w_rr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_s1_adv && req_valid) begin
            r_s1_match     <= w_match;
            r_s1_any_inv   <= w_any_inv;
            r_s1_first_inv <= w_first_inv;
            r_s1_user      <= req_user;
        end
        if (w_s2_adv && r_s1_v) begin
            r_resp_hit     <= w_hit;
            r_resp_way_oh  <= w_way_oh;
            r_resp_way     <= w_way;
            r_resp_victim  <= w_victim;
            r_resp_user    <= r_s1_user;
            r_resp_any_inv <= r_s1_any_inv;
        end
    end

`ifdef MC_TAG_MULTIHIT_EN
    logic r_resp_multi;
    logic r_err;

    always_ff @(posedge clk) begin
        if (w_s2_adv && r_s1_v) r_resp_multi <= |(r_s1_match & (r_s1_match - WAYS'(1)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end else if (w_resp_fire && r_resp_multi) begin
            r_err <= 1'b1;
        end
    end

    assign err_multihit = r_err;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;
    assign err_multihit     = 1'b0;
`endif

    assign resp_valid  = r_resp_valid;
    assign resp_hit    = r_resp_hit;
    assign resp_way_oh = r_resp_way_oh;
    assign resp_way    = r_resp_way;
    assign resp_victim = r_resp_victim;
    assign resp_user   = r_resp_user;

endmodule

`default_nettype wire

// File: tb/tb_mc_tag_lookup.sv
// ============================================================================
// Module : tb_mc_tag_lookup
// Brief  : Scoreboard bench for mc_tag_lookup (WAYS=4 main instance, WAYS=3 wrap instance).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mc_tag_lookup;

    localparam int TW = 12;
    localparam int W  = 4;
    localparam int UW = 4;
    localparam int WL = 2;
`ifdef MC_TAG_MULTIHIT_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [TW-1:0]   req_ref = '0;
    logic [W*TW-1:0] req_tags = '0;
    logic [W-1:0]    req_tvld = '0;
    logic [UW-1:0]   req_user = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b1;
    logic            resp_hit;
    logic [W-1:0]    resp_way_oh;
    logic [WL-1:0]   resp_way;
    logic [WL-1:0]   resp_victim;
    logic [UW-1:0]   resp_user;
    logic            err_multihit;
    logic            err_clr = 1'b0;

    mc_tag_lookup #(.TAG_WIDTH(TW), .WAYS(W), .USER_WIDTH(UW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_ref(req_ref),
        .req_tags(req_tags), .req_tvld(req_tvld), .req_user(req_user),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
        .resp_way_oh(resp_way_oh), .resp_way(resp_way), .resp_victim(resp_victim),
        .resp_user(resp_user), .err_multihit(err_multihit), .err_clr(err_clr)
    );

    // Second instance, WAYS=3, for non-power-of-2 round-robin wrap.
    logic            d3_req_valid = 1'b0;
    logic            d3_req_ready;
    logic [3*TW-1:0] d3_req_tags = {12'h300, 12'h200, 12'h100};
    logic            d3_resp_valid;
    logic            d3_resp_hit;
    logic [2:0]      d3_resp_way_oh;
    logic [1:0]      d3_resp_way;
    logic [1:0]      d3_resp_victim;
    logic [UW-1:0]   d3_resp_user;
    logic            d3_err;

    mc_tag_lookup #(.TAG_WIDTH(TW), .WAYS(3), .USER_WIDTH(UW)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(d3_req_valid), .req_ready(d3_req_ready), .req_ref(12'hFFF),
        .req_tags(d3_req_tags), .req_tvld(3'b111), .req_user(4'h0),
        .resp_valid(d3_resp_valid), .resp_ready(1'b1), .resp_hit(d3_resp_hit),
        .resp_way_oh(d3_resp_way_oh), .resp_way(d3_resp_way), .resp_victim(d3_resp_victim),
        .resp_user(d3_resp_user), .err_multihit(d3_err), .err_clr(1'b0)
    );

    typedef struct packed {
        logic          hit;
        logic [W-1:0]  oh;
        logic [WL-1:0] way;
        logic [WL-1:0] victim;
        logic [UW-1:0] user;
    } exp_t;

    exp_t q[$];
    exp_t obs;
    exp_t held;
    logic held_v = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   model_rr = 0;
    int   rmode = 0;
    int   d3_idx = 0;
    logic [1:0] d3_exp [4] = '{2'd0, 2'd1, 2'd2, 2'd0};

    assign obs = '{hit: resp_hit, oh: resp_way_oh, way: resp_way,
                   victim: resp_victim, user: resp_user};

    // resp_ready changes just after the rising edge: 0 = always ready, 1 = toggle, 2 = stalled.
    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       resp_ready = 1'b1;
            1:       resp_ready = ~resp_ready;
            default: resp_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                checks++;
                assert (resp_valid === 1'b1 && obs === held) else begin
                    errors++;
                    $error("FAIL stall_hold observed=%b/%h expected=1/%h", resp_valid, obs, held);
                end
            end
            if (resp_valid && resp_ready) begin
                checks++;
                assert (q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_resp observed=%h expected=no response", obs);
                end
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    checks++;
                    assert (obs === e) else begin
                        errors++;
                        $error("FAIL resp hit/oh/way/vic/user observed=%b/%b/%0d/%0d/%h expected=%b/%b/%0d/%0d/%h",
                               obs.hit, obs.oh, obs.way, obs.victim, obs.user,
                               e.hit, e.oh, e.way, e.victim, e.user);
                    end
                end
                held_v = 1'b0;
            end else if (resp_valid) begin
                held_v = 1'b1;
                held   = obs;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && d3_resp_valid) begin
            checks++;
            assert (d3_idx < 4 && d3_resp_hit === 1'b0 && d3_resp_victim === d3_exp[d3_idx[1:0]]) else begin
                errors++;
                $error("FAIL w3_victim idx=%0d observed=%0d hit=%b expected=%0d hit=0",
                       d3_idx, d3_resp_victim, d3_resp_hit, d3_exp[d3_idx[1:0]]);
            end
            d3_idx++;
        end
    end

    task automatic push_exp(input logic [TW-1:0] r, input logic [W*TW-1:0] t,
                            input logic [W-1:0] v, input logic [UW-1:0] u);
        exp_t e;
        logic found = 1'b0;
        int   inv = -1;
        e = '0;
        e.user = u;
        for (int w = 0; w < W; w++) begin
            if (v[w] && t[w*TW +: TW] == r && !found) begin
                found    = 1'b1;
                e.hit    = 1'b1;
                e.oh[w]  = 1'b1;
                e.way    = WL'(w);
            end
            if (!v[w] && inv < 0) inv = w;
        end
        if (inv >= 0) begin
            e.victim = WL'(inv);
        end else begin
            e.victim = WL'(model_rr);
            if (!found) model_rr = (model_rr + 1) % W;
        end
        q.push_back(e);
    endtask

    task automatic send(input logic [TW-1:0] r, input logic [W*TW-1:0] t,
                        input logic [W-1:0] v, input logic [UW-1:0] u);
        int n = 0;
        @(negedge clk);
        req_ref = r; req_tags = t; req_tvld = v; req_user = u; req_valid = 1'b1;
        #1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        assert (req_ready === 1'b1) else begin
            errors++;
            $error("FAIL req_accept observed=%b expected=1", req_ready);
        end
        push_exp(r, t, v, u);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL drain_timeout observed=%0d pending expected=0", q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [W*TW-1:0] base_tags;
    logic [TW-1:0]   r4;

    initial begin
        base_tags = {12'h333, 12'h222, 12'hABC, 12'h111};
        #2;
        checks++;
        assert (resp_valid === 1'b0 && req_ready === 1'b1 && err_multihit === 1'b0) else begin
            errors++;
            $error("FAIL reset_state observed=%b%b%b expected=010", resp_valid, req_ready, err_multihit);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Hit on way 1 with 2-cycle latency.
        send(12'hABC, base_tags, 4'b1111, 4'h1);
        idle();
        checks++;
        assert (resp_valid === 1'b0) else begin
            errors++; $error("FAIL latency_c1 observed=%b expected=0", resp_valid);
        end
        @(negedge clk);
        checks++;
        assert (resp_valid === 1'b1) else begin
            errors++; $error("FAIL latency_c2 observed=%b expected=1", resp_valid);
        end
        drain();

        // Miss because the matching way is invalid: victim is the invalid way.
        send(12'h222, base_tags, 4'b1011, 4'h2);
        idle();
        drain();

        // Round-robin victims 0,1,2,3,0 across back-to-back full-valid misses.
        for (int i = 0; i < 5; i++) send(12'hFFF, base_tags, 4'b1111, UW'(i + 3));
        idle();
        drain();

        // WAYS=3 wrap: 0,1,2,0.
        @(negedge clk);
        d3_req_valid = 1'b1;
        repeat (4) @(negedge clk);
        d3_req_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        assert (d3_idx == 4) else begin
            errors++; $error("FAIL w3_count observed=%0d expected=4", d3_idx);
        end

        // Streamed requests with toggling resp_ready.
        rmode = 1;
        for (int i = 0; i < 8; i++) begin
            r4 = (i % 2 == 0) ? base_tags[(i % 4) * TW +: TW] : 12'h5A5;
            send(r4, base_tags, 4'b1111, UW'(i + 8));
        end
        idle();
        drain();
        rmode = 0;

        // Multi-hit: ways 0 and 3 match.
        send(12'h777, {12'h777, 12'h222, 12'h111, 12'h777}, 4'b1111, 4'hC);
        idle();
        drain();
        checks++;
        assert (err_multihit === EXP_ERR) else begin
            errors++; $error("FAIL multihit_set observed=%b expected=%b", err_multihit, EXP_ERR);
        end
        repeat (2) @(negedge clk);
        checks++;
        assert (err_multihit === EXP_ERR) else begin
            errors++; $error("FAIL multihit_sticky observed=%b expected=%b", err_multihit, EXP_ERR);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        assert (err_multihit === 1'b0) else begin
            errors++; $error("FAIL multihit_clr observed=%b expected=0", err_multihit);
        end

        // Reset with two lookups in flight.
        rmode = 2;
        @(negedge clk);
        send(12'hABC, base_tags, 4'b1111, 4'hD);
        send(12'h111, base_tags, 4'b1111, 4'hE);
        idle();
        checks++;
        assert (resp_valid === 1'b1) else begin
            errors++; $error("FAIL inflight observed=%b expected=1", resp_valid);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        assert (resp_valid === 1'b0) else begin
            errors++; $error("FAIL reset_async observed=%b expected=0", resp_valid);
        end
        q.delete();
        model_rr = 0;
        rmode = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            assert (resp_valid === 1'b0) else begin
                errors++; $error("FAIL stale_resp cycle=%0d observed=%b expected=0", i, resp_valid);
            end
        end

        // Pipeline is usable again after reset.
        send(12'h333, base_tags, 4'b1111, 4'hF);
        idle();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
